mini_mem_ctrl: RTL and testbench
================================

Name: mini_mem_ctrl

Overview:
- Data-memory controller directly downstream of the `mini` core. It consumes the core's read/write strobes and returns read data plus a completion acknowledge.
- Owns a single-port RAM and inserts a programmable number of wait states to model slow memory.
- Its `busy` output drives the core's stall path.

Parameters:
- AW, 8, address width in bits; memory depth is 2**AW words
- DW, 8, data word width in bits
- WAIT_CYCLES, 2, wait states inserted before each access (0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request from the core, sampled only in IDLE
- we  in  1  1 = write, 0 = read; qualified by req
- addr  in  AW  word address; qualified by req
- wdata  in  DW  write data; qualified by req
- rdata  out  DW  read data; valid when ack=1, then held
- ack  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after req is accepted until ack is issued
- err  out  1  address-range error, pulses with ack; present only with MINI_MEM_ADDR_CHECK_EN

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, rdata=0, ack=0, busy=0, err=0, wait counter=0.
  - RAM contents are NOT reset.
- FSM states and transitions:
  - IDLE: if req=1, latch we/addr/wdata into the request register, set busy=1, then go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
  - WAIT: counter increments each cycle; when counter==WAIT_CYCLES-1, clear it and go to ACCESS.
  - ACCESS:
    - write: RAM[addr] <= wdata.
    - read: rdata <= RAM[addr].
    - Go to DONE.
  - DONE: ack=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: req sampled at edge N gives ack high during cycle N+WAIT_CYCLES+2. With default 2, ack is seen 4 cycles after acceptance.
- Request handling:
  - req is ignored outside IDLE; no queuing, no overwrite of the latched request.
  - The core holds or reissues req only after ack.
  - req asserted in the same cycle as ack (DONE) is ignored; it is accepted the following cycle if still high.
- rdata:
  - Updates only on read completion.
  - Writes leave rdata unchanged.
  - rdata holds its value across idle cycles.
- Back-to-back accesses: minimum spacing between acks is WAIT_CYCLES+3 cycles.
- Read-after-write to the same address returns the newly written data; there is no hazard, since accesses are serialized.
- Address wrap: addr is exactly AW bits wide, so there is no wrap logic.
- Reset mid-operation:
  - Returns to IDLE immediately; no ack is issued.
  - A write is committed only if ACCESS had already completed before reset asserted.
- Changes to we/addr/wdata after acceptance have no effect.

Optional Feature:
- MINI_MEM_ADDR_CHECK_EN defined:
  - Adds the `err` port and parameter MAX_ADDR (default 2**AW-1).
  - A request with addr>MAX_ADDR still walks WAIT→ACCESS→DONE, but suppresses the RAM write, returns rdata=0, and pulses err=1 together with ack.
- Undefined:
  - No `err` port.
  - All addresses are legal and timing is identical.

Decomposition:
- Shared package `mini_pkg` holds:
  - the state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_ACCESS=2'd2, ST_DONE=2'd3;
  - the default AW/DW widths used by the core.
- One sub-module, `mini_ram`: synchronous single-port RAM with inputs clk, en, we, addr, wdata and a registered rdata output.
- The FSM, wait counter and request register stay in mini_mem_ctrl.

Test Plan:
- Reset check:
  - Stimulus: assert rst mid-cycle, then release.
  - Response: rdata=0, ack=0, busy=0 immediately, since reset is asynchronous.
- Basic write/read:
  - Stimulus: write addr=8'h10 wdata=8'hA5; after ack, read addr=8'h10.
  - Response: ack 4 cycles after each acceptance; rdata=8'hA5 with ack.
- Busy/ignore:
  - Stimulus: hold req=1 continuously with alternating addresses 8'h01/8'h02 changing every cycle.
  - Response: busy high for 4 cycles per access; only the address latched in IDLE is used; one ack every 5 cycles.
- Zero-wait:
  - Stimulus: WAIT_CYCLES=0; write 8'h3C to 8'hFF, then read 8'hFF.
  - Response: ack 2 cycles after acceptance; rdata=8'h3C.
- Reset mid-write:
  - Stimulus: write 8'h77 to 8'h20 (prior contents 8'h11), assert rst while in WAIT, then read 8'h20.
  - Response: no ack for the aborted write; the read returns 8'h11.
- Address check (MINI_MEM_ADDR_CHECK_EN, MAX_ADDR=8'h7F):
  - Stimulus: write 8'h55 to 8'h80, then read 8'h80.
  - Response: err=1 with both acks; rdata=0; RAM unchanged.

Source files
------------

// File: rtl/mini_pkg.sv
// Shared definitions for the mini core and its memory controller:
// FSM state encoding and the default bus widths.
package mini_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned MINI_AW = 8;
  localparam int unsigned MINI_DW = 8;

endpackage

// File: rtl/mini_ram.sv
// Synchronous single-port RAM with a registered read port.
// The read register only updates on an enabled read, so it holds between reads.
// Contents are not reset.
module mini_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  // Single access per enabled cycle: write the array or capture a read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mini_mem_ctrl.sv
// Data-memory controller for the mini core: serialises one access at a time,
// inserts WAIT_CYCLES wait states and signals completion with a one-cycle ack.
// Optional address range checking (err port, MAX_ADDR parameter) is enabled
// by defining MINI_MEM_ADDR_CHECK_EN.
module mini_mem_ctrl
  import mini_pkg::*;
#(
  parameter int unsigned AW          = MINI_AW,
  parameter int unsigned DW          = MINI_DW,
  parameter int unsigned WAIT_CYCLES = 2
`ifdef MINI_MEM_ADDR_CHECK_EN
  ,
  parameter int unsigned MAX_ADDR    = (1 << AW) - 1
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy
`ifdef MINI_MEM_ADDR_CHECK_EN
  ,
  output logic          err
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          accept;

  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_bad;
  logic          addr_bad;

  logic          ram_en;
  logic [DW-1:0] ram_rdata;
  logic          rdata_sel;

`ifdef MINI_MEM_ADDR_CHECK_EN
  assign addr_bad = (32'(addr) > MAX_ADDR);
`else
  assign addr_bad = 1'b0;
`endif

  // Next-state logic: accept in IDLE, count wait states, single access, done.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          cnt_next   = '0;
          state_next = ST_ACCESS;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_ACCESS: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request register: captured only on acceptance, immune to later input changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_bad   <= 1'b0;
    end else if (accept) begin
      req_we    <= we;
      req_addr  <= addr;
      req_wdata <= wdata;
      req_bad   <= addr_bad;
    end
  end

  // Status outputs: busy spans WAIT..DONE, ack (and err) mark the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      ack       <= 1'b0;
      rdata_sel <= 1'b0;
`ifdef MINI_MEM_ADDR_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      if (accept)                busy <= 1'b1;
      else if (state == ST_DONE) busy <= 1'b0;
      ack <= (state == ST_ACCESS);
`ifdef MINI_MEM_ADDR_CHECK_EN
      err <= (state == ST_ACCESS) && req_bad;
`endif
      if (state == ST_ACCESS && !req_we) rdata_sel <= !req_bad;
    end
  end

  // The RAM read register has no reset; rdata_sel forces the visible value to
  // zero after reset or a rejected read until the next good read completes.
  assign rdata  = rdata_sel ? ram_rdata : '0;
  assign ram_en = (state == ST_ACCESS) && !req_bad;

  mini_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (req_we),
    .addr (req_addr),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mini_mem_ctrl.sv
// Directed bench for mini_mem_ctrl: a default-timing instance and a
// zero-wait instance share clock and reset.
module tb_mini_mem_ctrl;

  logic       clk;
  logic       rst;
  logic       req, we;
  logic [7:0] addr, wdata, rdata;
  logic       ack, busy;
  logic       req0, we0;
  logic [7:0] addr0, wdata0, rdata0;
  logic       ack0, busy0;
`ifdef MINI_MEM_ADDR_CHECK_EN
  logic       err, err0;
`endif

  int n_chk = 0;
  int n_err = 0;

  mini_mem_ctrl #(
    .AW(8),
    .DW(8),
    .WAIT_CYCLES(2)
`ifdef MINI_MEM_ADDR_CHECK_EN
    ,
    .MAX_ADDR('h7F)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy)
`ifdef MINI_MEM_ADDR_CHECK_EN
    , .err(err)
`endif
  );

  mini_mem_ctrl #(
    .AW(8),
    .DW(8),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0)
`ifdef MINI_MEM_ADDR_CHECK_EN
    , .err(err0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; starts and ends at a negedge in IDLE.
  task automatic acc2(input string tag, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      chk($sformatf("%s_busy%0d", tag, i), busy, 1);
      chk($sformatf("%s_ack%0d", tag, i), ack, (i == 4));
    end
    chk($sformatf("%s_rdata", tag), rdata, exp_rd);
`ifdef MINI_MEM_ADDR_CHECK_EN
    chk($sformatf("%s_err", tag), err, exp_err);
`else
    if (exp_err) chk($sformatf("%s_err_unsupported", tag), 0, 1);
`endif
    @(negedge clk);
    chk($sformatf("%s_ack_end", tag), ack, 0);
    chk($sformatf("%s_busy_end", tag), busy, 0);
  endtask

  // One access on the zero-wait instance.
  task automatic acc0(input string tag, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); @(negedge clk);
    req0 = 1'b0; we0 = ~w; addr0 = ~a; wdata0 = ~d;
    chk($sformatf("%s_busy1", tag), busy0, 1);
    chk($sformatf("%s_ack1", tag), ack0, 0);
    @(negedge clk);
    chk($sformatf("%s_ack2", tag), ack0, 1);
    chk($sformatf("%s_rdata", tag), rdata0, exp_rd);
    @(negedge clk);
    chk($sformatf("%s_ack_end", tag), ack0, 0);
    chk($sformatf("%s_busy_end", tag), busy0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst0_rdata", rdata0, 0);
    chk("rst0_ack", ack0, 0);
    chk("rst0_busy", busy0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read-back; the write leaves rdata at 0.
    acc2("wr10", 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    acc2("rd10", 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    chk("rd10_hold", rdata, 8'hA5);

    // Reset during WAIT aborts the write of 8'h77.
    acc2("wr20", 1'b1, 8'h20, 8'h11, 8'hA5, 1'b0);
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    chk("abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_busyrst", busy, 0);
    chk("abort_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort_noack%0d", i), ack, 0);
    end
    acc2("rd20", 1'b0, 8'h20, 8'h00, 8'h11, 1'b0);

    // Continuous req with address toggling each cycle: accepts at edges 0,5,10.
    acc2("wr01", 1'b1, 8'h01, 8'h5A, 8'h11, 1'b0);
    acc2("wr02", 1'b1, 8'h02, 8'hC3, 8'h11, 1'b0);
    req = 1'b1; we = 1'b0; addr = 8'h01;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold_ack%0d", k), ack, (k % 5 == 3));
      chk($sformatf("hold_busy%0d", k), busy, (k % 5 != 4));
      if (k == 3)  chk("hold_rd_a", rdata, 8'h5A);
      if (k == 8)  chk("hold_rd_b", rdata, 8'hC3);
      if (k == 13) chk("hold_rd_c", rdata, 8'h5A);
      addr = ((k + 1) % 2 == 0) ? 8'h01 : 8'h02;
    end
    req = 1'b0;
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);

    // Zero wait states: ack in the second cycle after acceptance.
    acc0("z_wrff", 1'b1, 8'hFF, 8'h3C, 8'h00);
    acc0("z_rdff", 1'b0, 8'hFF, 8'h00, 8'h3C);

`ifdef MINI_MEM_ADDR_CHECK_EN
    // Out-of-range accesses complete with err and zero read data.
    acc2("bad_wr80", 1'b1, 8'h80, 8'h55, 8'h5A, 1'b1);
    acc2("bad_rd80", 1'b0, 8'h80, 8'h00, 8'h00, 1'b1);
    acc2("ok_rd7f_wr", 1'b1, 8'h7F, 8'h66, 8'h00, 1'b0);
    acc2("ok_rd7f", 1'b0, 8'h7F, 8'h00, 8'h66, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
